// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM pattern tester: FSM encoding, pattern modes,
// LFSR tap masks and seed folding.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_REQ  = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_DONE      = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADDR     = 2'd0,
    MODE_INV_ADDR = 2'd1,
    MODE_WALK1    = 2'd2,
    MODE_LFSR     = 2'd3
  } mode_e;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  // Right-shifting Galois tap mask for the supported data widths.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] t;
    case (width)
      8:       t = {24'h0, LFSR_TAPS_8};
      16:      t = {16'h0, LFSR_TAPS_16};
      default: t = LFSR_TAPS_32;
    endcase
    return t;
  endfunction

  // {pass[7:0], 8'hA5}: XOR-folded for 8 bits, zero-extended otherwise; never zero.
  function automatic logic [31:0] lfsr_seed(input logic [7:0] pass_lsb, input int unsigned width);
    logic [15:0] raw;
    logic [31:0] s;
    raw = {pass_lsb, 8'hA5};
    case (width)
      8:       s = {24'h0, raw[15:8] ^ raw[7:0]};
      default: s = {16'h0, raw};
    endcase
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test-pattern generator: pattern for one address plus the
// following LFSR state.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] lfsr_i,
  output logic [DATA_W-1:0] pattern_o,
  output logic [DATA_W-1:0] lfsr_next_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] addr_ext;

  assign addr_ext = DATA_W'(addr_i);

  always_comb begin
    pattern_o = '0;
    case (mode_e'(mode_i))
      MODE_ADDR:     pattern_o = addr_ext;
      MODE_INV_ADDR: pattern_o = ~addr_ext;
      MODE_WALK1:    pattern_o = ONE << addr_i[SH_W-1:0];
      default:       pattern_o = lfsr_i;
    endcase
  end

  assign lfsr_next_o = (lfsr_i >> 1) ^ (lfsr_i[0] ? TAPS : '0);

endmodule

// File: rtl/sdram_pattern_tester.sv
// Memory tester: writes a pattern over an address range through a simple
// request/busy controller port, reads it back one word at a time and compares.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = '1,
  parameter int unsigned       AUTO_START = 1,
  parameter int unsigned       TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              continuous,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [DATA_W-1:0] data_in,
  output logic              in_valid,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_out,
  input  logic              out_valid,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic [15:0]       error_count,
  output logic [15:0]       pass_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [7:0]        leds
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              inv_q, inv_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              tmo_q, tmo_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] wr_lfsr_q, wr_lfsr_d;
  logic [DATA_W-1:0] rd_lfsr_q, rd_lfsr_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              first_q;

  logic [DATA_W-1:0] wr_pat, wr_next, rd_pat, rd_next;
  logic [DATA_W-1:0] seed_cur, seed_nxt;
  logic [7:0]        pass_lsb_nxt;
  logic              accepted, tmo_hit;

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
    .mode_i      (mode_q),
    .addr_i      (cur_q),
    .lfsr_i      (wr_lfsr_q),
    .pattern_o   (wr_pat),
    .lfsr_next_o (wr_next)
  );

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_gen (
    .mode_i      (mode_q),
    .addr_i      (cur_q),
    .lfsr_i      (rd_lfsr_q),
    .pattern_o   (rd_pat),
    .lfsr_next_o (rd_next)
  );

  assign pass_lsb_nxt = pass_cnt_q[7:0] + 8'd1;
  assign seed_cur     = DATA_W'(lfsr_seed(pass_cnt_q[7:0], DATA_W));
  assign seed_nxt     = DATA_W'(lfsr_seed(pass_lsb_nxt, DATA_W));
  assign accepted     = inv_q && !busy;
  assign tmo_hit      = (wait_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      data_q     <= '0;
      inv_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tmo_q      <= 1'b0;
      err_cnt_q  <= '0;
      pass_cnt_q <= '0;
      ffa_q      <= '0;
      cur_q      <= '0;
      wr_lfsr_q  <= '0;
      rd_lfsr_q  <= '0;
      wait_q     <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      data_q     <= data_d;
      inv_q      <= inv_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tmo_q      <= tmo_d;
      err_cnt_q  <= err_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      ffa_q      <= ffa_d;
      cur_q      <= cur_d;
      wr_lfsr_q  <= wr_lfsr_d;
      rd_lfsr_q  <= rd_lfsr_d;
      wait_q     <= wait_d;
      first_q    <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    data_d     = data_q;
    inv_d      = inv_q;
    done_d     = done_q;
    error_d    = error_q;
    tmo_d      = tmo_q;
    err_cnt_d  = err_cnt_q;
    pass_cnt_d = pass_cnt_q;
    ffa_d      = ffa_q;
    cur_d      = cur_q;
    wr_lfsr_d  = wr_lfsr_q;
    rd_lfsr_d  = rd_lfsr_q;
    wait_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start || ((AUTO_START != 0) && first_q)) begin
          state_d   = ST_WRITE;
          mode_d    = mode;
          cur_d     = START_ADDR;
          wr_lfsr_d = seed_cur;
        end
      end

      // cur_q runs one address ahead of the request register in this state.
      ST_WRITE: begin
        if (inv_q && busy) begin
          if (tmo_hit) begin
            tmo_d   = 1'b1;
            inv_d   = 1'b0;
            state_d = ST_HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else if (accepted && (addr_q == END_ADDR)) begin
          inv_d     = 1'b0;
          state_d   = ST_READ_REQ;
          cur_d     = START_ADDR;
          rd_lfsr_d = seed_cur;
        end else begin
          inv_d     = 1'b1;
          rw_d      = 1'b1;
          addr_d    = cur_q;
          data_d    = wr_pat;
          cur_d     = cur_q + 1'b1;
          wr_lfsr_d = wr_next;
        end
      end

      ST_READ_REQ: begin
        if (!inv_q) begin
          inv_d  = 1'b1;
          rw_d   = 1'b0;
          addr_d = cur_q;
        end else if (busy) begin
          if (tmo_hit) begin
            tmo_d   = 1'b1;
            inv_d   = 1'b0;
            state_d = ST_HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          inv_d   = 1'b0;
          state_d = ST_READ_WAIT;
        end
      end

      ST_READ_WAIT: begin
        if (out_valid) begin
          if (data_out != rd_pat) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (!error_q) ffa_d = cur_q;
          end
          if (cur_q == END_ADDR) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
            if (continuous) begin
              state_d   = ST_WRITE;
              cur_d     = START_ADDR;
              wr_lfsr_d = seed_nxt;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cur_d     = cur_q + 1'b1;
            rd_lfsr_d = rd_next;
            state_d   = ST_READ_REQ;
          end
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (start) begin
          done_d    = 1'b0;
          err_cnt_d = '0;
          state_d   = ST_WRITE;
          mode_d    = mode;
          cur_d     = START_ADDR;
          wr_lfsr_d = seed_cur;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign addr            = addr_q;
  assign rw              = rw_q;
  assign data_in         = data_q;
  assign in_valid        = inv_q;
  assign done            = done_q;
  assign error           = error_q;
  assign timeout         = tmo_q;
  assign error_count     = err_cnt_q;
  assign pass_count      = pass_cnt_q;
  assign first_fail_addr = ffa_q;
  assign leds            = {error_q, tmo_q, done_q, pass_cnt_q[4:0]};

endmodule
